// File: rtl/intersection_phase_ctrl.sv
// Tick-timed phase sequencer for a NS/EW intersection with pedestrian crossing.
// NS rests in green; every right-of-way change passes through yellow and all-red.
module intersection_phase_ctrl #(
  parameter int CNT_W     = 8,
  parameter int GREEN_MIN = 20,
  parameter int GREEN_MAX = 60,
  parameter int YELLOW_T  = 4,
  parameter int ALLRED_T  = 2,
  parameter int WALK_T    = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       car_ew,
  input  logic       ped_req,
  input  logic       preempt,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    ST_ALLRED = 3'd0,
    ST_NS_GRN = 3'd1,
    ST_NS_YEL = 3'd2,
    ST_EW_GRN = 3'd3,
    ST_EW_YEL = 3'd4,
    ST_WALK   = 3'd5
  } state_t;

  localparam logic [CNT_W:0]   GMIN = (CNT_W+1)'(GREEN_MIN);
  localparam logic [CNT_W:0]   GMAX = (CNT_W+1)'(GREEN_MAX);
  localparam logic [CNT_W:0]   YEL  = (CNT_W+1)'(YELLOW_T);
  localparam logic [CNT_W:0]   ARED = (CNT_W+1)'(ALLRED_T);
  localparam logic [CNT_W:0]   WLK  = (CNT_W+1)'(WALK_T);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t             state, state_nxt;
  state_t             dest, dest_nxt;
  logic [CNT_W-1:0]   timer, timer_nxt, timer_inc;
  logic [CNT_W:0]     elapsed;
  logic               ped_nxt;

  // elapsed is one bit wider so a saturated timer still compares correctly
  assign elapsed   = {1'b0, timer} + (CNT_W+1)'(1);
  assign timer_inc = (tick && (timer != '1)) ? timer + ONE : timer;

  always_comb begin
    state_nxt = state;
    dest_nxt  = dest;
    timer_nxt = timer_inc;
    case (state)
      ST_ALLRED: begin
        if (preempt)
          timer_nxt = '0;
        else if (tick && elapsed >= ARED)
          state_nxt = dest;
      end
      ST_NS_GRN: begin
        if (preempt || (tick && elapsed >= GMIN && (car_ew || ped_pending)))
          state_nxt = ST_NS_YEL;
      end
      ST_NS_YEL: begin
        if (tick && elapsed >= YEL) begin
          state_nxt = ST_ALLRED;
          dest_nxt  = ped_pending ? ST_WALK : ST_EW_GRN;
        end
      end
      ST_EW_GRN: begin
        if (preempt || (tick && (elapsed >= GMAX || (elapsed >= GMIN && !car_ew))))
          state_nxt = ST_EW_YEL;
      end
      ST_EW_YEL: begin
        if (tick && elapsed >= YEL) begin
          state_nxt = ST_ALLRED;
          dest_nxt  = ST_NS_GRN;
        end
      end
      ST_WALK: begin
        if (tick && elapsed >= WLK) begin
          state_nxt = ST_ALLRED;
          dest_nxt  = car_ew ? ST_EW_GRN : ST_NS_GRN;
        end
      end
      default: begin
        state_nxt = ST_ALLRED;
        dest_nxt  = ST_NS_GRN;
      end
    endcase
    if (preempt)
      dest_nxt = ST_NS_GRN;
    if (state_nxt != state)
      timer_nxt = '0;
  end

  // A button press on the same edge that enters WALK is served by that walk
  always_comb begin
    ped_nxt = ped_pending;
    if (state_nxt == ST_WALK && state != ST_WALK)
      ped_nxt = 1'b0;
    else if (ped_req && state != ST_WALK)
      ped_nxt = 1'b1;
  end

  // Lamps are decoded from the next state so they register alongside it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_ALLRED;
      dest        <= ST_NS_GRN;
      timer       <= '0;
      ped_pending <= 1'b0;
      phase       <= 3'd0;
      ns_red      <= 1'b1;
      ns_yellow   <= 1'b0;
      ns_green    <= 1'b0;
      ew_red      <= 1'b1;
      ew_yellow   <= 1'b0;
      ew_green    <= 1'b0;
      walk        <= 1'b0;
    end else begin
      state       <= state_nxt;
      dest        <= dest_nxt;
      timer       <= timer_nxt;
      ped_pending <= ped_nxt;
      phase       <= state_nxt;
      ns_red      <= 1'b1;
      ns_yellow   <= 1'b0;
      ns_green    <= 1'b0;
      ew_red      <= 1'b1;
      ew_yellow   <= 1'b0;
      ew_green    <= 1'b0;
      walk        <= 1'b0;
      case (state_nxt)
        ST_NS_GRN: begin ns_red <= 1'b0; ns_green  <= 1'b1; end
        ST_NS_YEL: begin ns_red <= 1'b0; ns_yellow <= 1'b1; end
        ST_EW_GRN: begin ew_red <= 1'b0; ew_green  <= 1'b1; end
        ST_EW_YEL: begin ew_red <= 1'b0; ew_yellow <= 1'b1; end
        ST_WALK:   walk <= 1'b1;
        default:   ;
      endcase
    end
  end

endmodule

// File: tb/tb_intersection_phase_ctrl.sv
// Directed bench for intersection_phase_ctrl using a small timing set
// (GREEN_MIN=3, GREEN_MAX=6, YELLOW_T=2, ALLRED_T=1, WALK_T=2).
module tb_intersection_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       car_ew = 1'b0;
  logic       ped_req = 1'b0;
  logic       preempt = 1'b0;
  logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk;
  logic       ped_pending;
  logic [2:0] phase;
  logic [6:0] lamps;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] L_ALLRED = 7'b1001000;
  localparam logic [6:0] L_NSGRN  = 7'b0011000;
  localparam logic [6:0] L_NSYEL  = 7'b0101000;
  localparam logic [6:0] L_EWGRN  = 7'b1000010;
  localparam logic [6:0] L_EWYEL  = 7'b1000100;
  localparam logic [6:0] L_WALK   = 7'b1001001;

  assign lamps = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk};

  intersection_phase_ctrl #(
    .CNT_W(4), .GREEN_MIN(3), .GREEN_MAX(6), .YELLOW_T(2), .ALLRED_T(1), .WALK_T(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .car_ew(car_ew), .ped_req(ped_req),
    .preempt(preempt), .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green), .walk(walk),
    .ped_pending(ped_pending), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic do_cycle(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b1);
  endtask

  task automatic tick_period(input int n);
    for (int i = 0; i < n; i++) begin
      do_cycle(1'b1);
      do_cycle(1'b0);
      do_cycle(1'b0);
      do_cycle(1'b0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; car_ew = 1'b0; ped_req = 1'b0; preempt = 1'b0;
    do_cycle(1'b0);
    do_cycle(1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({phase, lamps, ped_pending} !== {3'd0, L_ALLRED, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_state: got phase=%0d lamps=%b pend=%b, want 0 %b 0",
               phase, lamps, ped_pending, L_ALLRED);
    end
    do_ticks(1);
    checks++;
    if ({phase, lamps} !== {3'd1, L_NSGRN}) begin
      errors++;
      $display("[TB] FAIL reset_to_ns: got phase=%0d lamps=%b, want 1 %b", phase, lamps, L_NSGRN);
    end
    for (int i = 0; i < 50; i++) begin
      do_ticks(1);
      checks++;
      if ({phase, lamps} !== {3'd1, L_NSGRN}) begin
        errors++;
        $display("[TB] FAIL ns_rest tick %0d: got phase=%0d lamps=%b, want 1 %b",
                 i, phase, lamps, L_NSGRN);
      end
    end
  endtask

  task automatic test_ew_max();
    do_reset();
    do_ticks(1);
    car_ew = 1'b1;
    do_ticks(2);
    checks++;
    if (phase !== 3'd1) begin
      errors++; $display("[TB] FAIL ew_max_min_green: got phase=%0d, want 1", phase);
    end
    do_ticks(1);
    checks++;
    if ({phase, lamps} !== {3'd2, L_NSYEL}) begin
      errors++; $display("[TB] FAIL ew_max_ns_yel: got phase=%0d lamps=%b, want 2 %b", phase, lamps, L_NSYEL);
    end
    do_ticks(1);
    checks++;
    if (phase !== 3'd2) begin
      errors++; $display("[TB] FAIL ew_max_yel_hold: got phase=%0d, want 2", phase);
    end
    do_ticks(1);
    checks++;
    if ({phase, lamps} !== {3'd0, L_ALLRED}) begin
      errors++; $display("[TB] FAIL ew_max_allred: got phase=%0d lamps=%b, want 0 %b", phase, lamps, L_ALLRED);
    end
    do_ticks(1);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({phase, lamps} !== {3'd3, L_EWGRN}) begin
        errors++; $display("[TB] FAIL ew_max_green elapsed %0d: got phase=%0d lamps=%b, want 3 %b",
                           i, phase, lamps, L_EWGRN);
      end
      do_ticks(1);
    end
    checks++;
    if ({phase, lamps} !== {3'd4, L_EWYEL}) begin
      errors++; $display("[TB] FAIL ew_max_ew_yel: got phase=%0d lamps=%b, want 4 %b", phase, lamps, L_EWYEL);
    end
  endtask

  task automatic test_ew_gap();
    do_reset();
    do_ticks(1);
    car_ew = 1'b1;
    do_ticks(6);
    do_ticks(3);
    checks++;
    if (phase !== 3'd3) begin
      errors++; $display("[TB] FAIL ew_gap_hold: got phase=%0d, want 3", phase);
    end
    car_ew = 1'b0;
    do_ticks(1);
    checks++;
    if ({phase, lamps} !== {3'd4, L_EWYEL}) begin
      errors++; $display("[TB] FAIL ew_gap_yel: got phase=%0d lamps=%b, want 4 %b", phase, lamps, L_EWYEL);
    end
    do_ticks(2);
    checks++;
    if (phase !== 3'd0) begin
      errors++; $display("[TB] FAIL ew_gap_allred: got phase=%0d, want 0", phase);
    end
    do_ticks(1);
    checks++;
    if ({phase, lamps} !== {3'd1, L_NSGRN}) begin
      errors++; $display("[TB] FAIL ew_gap_ns_back: got phase=%0d lamps=%b, want 1 %b", phase, lamps, L_NSGRN);
    end
  endtask

  task automatic test_ped();
    do_reset();
    do_ticks(1);
    car_ew = 1'b1;
    ped_req = 1'b1;
    do_cycle(1'b0);
    ped_req = 1'b0;
    checks++;
    if ({phase, ped_pending} !== {3'd1, 1'b1}) begin
      errors++; $display("[TB] FAIL ped_latch: got phase=%0d pend=%b, want 1 1", phase, ped_pending);
    end
    do_ticks(5);
    checks++;
    if ({phase, ped_pending} !== {3'd0, 1'b1}) begin
      errors++; $display("[TB] FAIL ped_allred: got phase=%0d pend=%b, want 0 1", phase, ped_pending);
    end
    ped_req = 1'b1;
    do_ticks(1);
    checks++;
    if ({phase, lamps, ped_pending} !== {3'd5, L_WALK, 1'b0}) begin
      errors++; $display("[TB] FAIL ped_walk_entry: got phase=%0d lamps=%b pend=%b, want 5 %b 0",
                         phase, lamps, ped_pending, L_WALK);
    end
    do_ticks(1);
    checks++;
    if ({phase, ped_pending} !== {3'd5, 1'b0}) begin
      errors++; $display("[TB] FAIL ped_walk_hold: got phase=%0d pend=%b, want 5 0", phase, ped_pending);
    end
    ped_req = 1'b0;
    do_ticks(1);
    checks++;
    if ({phase, lamps} !== {3'd0, L_ALLRED}) begin
      errors++; $display("[TB] FAIL ped_walk_exit: got phase=%0d lamps=%b, want 0 %b", phase, lamps, L_ALLRED);
    end
    do_ticks(1);
    checks++;
    if ({phase, ped_pending} !== {3'd3, 1'b0}) begin
      errors++; $display("[TB] FAIL ped_to_ew: got phase=%0d pend=%b, want 3 0", phase, ped_pending);
    end
  endtask

  task automatic test_preempt_ew();
    do_reset();
    tick_period(1);
    car_ew = 1'b1;
    tick_period(6);
    checks++;
    if (phase !== 3'd3) begin
      errors++; $display("[TB] FAIL pre_ew_reach: got phase=%0d, want 3", phase);
    end
    tick_period(1);
    preempt = 1'b1;
    do_cycle(1'b0);
    checks++;
    if ({phase, lamps} !== {3'd4, L_EWYEL}) begin
      errors++; $display("[TB] FAIL pre_ew_force_yel: got phase=%0d lamps=%b, want 4 %b", phase, lamps, L_EWYEL);
    end
    tick_period(1);
    checks++;
    if (phase !== 3'd4) begin
      errors++; $display("[TB] FAIL pre_ew_yel_full: got phase=%0d, want 4", phase);
    end
    tick_period(1);
    tick_period(3);
    checks++;
    if ({phase, lamps} !== {3'd0, L_ALLRED}) begin
      errors++; $display("[TB] FAIL pre_ew_hold: got phase=%0d lamps=%b, want 0 %b", phase, lamps, L_ALLRED);
    end
    preempt = 1'b0;
    do_cycle(1'b0);
    checks++;
    if (phase !== 3'd0) begin
      errors++; $display("[TB] FAIL pre_ew_release_wait: got phase=%0d, want 0", phase);
    end
    do_cycle(1'b1);
    checks++;
    if ({phase, lamps} !== {3'd1, L_NSGRN}) begin
      errors++; $display("[TB] FAIL pre_ew_release_ns: got phase=%0d lamps=%b, want 1 %b", phase, lamps, L_NSGRN);
    end
  endtask

  task automatic test_preempt_ns();
    do_reset();
    do_ticks(1);
    ped_req = 1'b1;
    do_cycle(1'b0);
    ped_req = 1'b0;
    preempt = 1'b1;
    do_cycle(1'b0);
    checks++;
    if (phase !== 3'd2) begin
      errors++; $display("[TB] FAIL pre_ns_force_yel: got phase=%0d, want 2", phase);
    end
    do_ticks(3);
    checks++;
    if (phase !== 3'd0) begin
      errors++; $display("[TB] FAIL pre_ns_hold: got phase=%0d, want 0", phase);
    end
    preempt = 1'b0;
    do_ticks(1);
    checks++;
    if ({phase, ped_pending} !== {3'd1, 1'b1}) begin
      errors++; $display("[TB] FAIL pre_ns_dest: got phase=%0d pend=%b, want 1 1", phase, ped_pending);
    end
  endtask

  task automatic test_reset_walk();
    do_reset();
    do_ticks(1);
    ped_req = 1'b1;
    do_cycle(1'b0);
    ped_req = 1'b0;
    do_ticks(6);
    checks++;
    if (phase !== 3'd5) begin
      errors++; $display("[TB] FAIL rst_walk_reach: got phase=%0d, want 5", phase);
    end
    ped_req = 1'b1;
    rst_n = 1'b0;
    do_cycle(1'b1);
    checks++;
    if ({phase, lamps, ped_pending} !== {3'd0, L_ALLRED, 1'b0}) begin
      errors++; $display("[TB] FAIL rst_walk: got phase=%0d lamps=%b pend=%b, want 0 %b 0",
                         phase, lamps, ped_pending, L_ALLRED);
    end
    rst_n = 1'b1;
    ped_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ew_max();
    test_ew_gap();
    test_ped();
    test_preempt_ew();
    test_preempt_ns();
    test_reset_walk();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
